// File: rtl/mem_dump_reader.sv
// mem_dump_reader: snapshots the flattened data-memory debug bus on request
// and streams it out byte by byte (MSB-first within each word) over a
// valid/ready handshake toward the debug UART transmitter.
// Optional build macro: MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte
// after the last data byte.
module mem_dump_reader #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int BYTE_SIZE     = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_start,
  input  logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0]     i_bus_debug,
  input  logic                                          i_tx_ready,
  output logic [BYTE_SIZE-1:0]                          o_tx_data,
  output logic                                          o_tx_valid,
  output logic                                          o_busy,
  output logic                                          o_done
);

  localparam int WORDS   = 2**MEM_ADDR_SIZE;
  localparam int TOTAL_W = WORDS*IO_BUS_SIZE;
  localparam int BPW     = IO_BUS_SIZE/BYTE_SIZE;
  localparam int BIW     = (BPW > 1) ? $clog2(BPW) : 1;
  // One spare bit so the word counter never aliases back to zero.
  localparam int WIW     = MEM_ADDR_SIZE + 1;

  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW-1);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS-1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t               state;
  logic [TOTAL_W-1:0]   snap;
  logic [WIW-1:0]       word_idx;
  logic [BIW-1:0]       byte_idx;
  logic [WIW-1:0]       nxt_word;
  logic [BIW-1:0]       nxt_byte;
  logic                 last_data;
  logic                 xfer;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic                 trailer;
  logic [BYTE_SIZE-1:0] xor_acc;
`endif

  // Byte b of word w, byte 0 being the most significant byte of the word.
  function automatic logic [BYTE_SIZE-1:0] pick(input logic [TOTAL_W-1:0] v,
                                                input logic [WIW-1:0]     w,
                                                input logic [BIW-1:0]     b);
    logic [TOTAL_W-1:0] s;
    s = v >> (int'(w)*IO_BUS_SIZE + IO_BUS_SIZE - (int'(b)+1)*BYTE_SIZE);
    return s[BYTE_SIZE-1:0];
  endfunction

  // Next byte/word position and end-of-data detection for the current byte.
  always_comb begin
    nxt_byte  = byte_idx + 1'b1;
    nxt_word  = word_idx;
    if (byte_idx == LAST_BYTE) begin
      nxt_byte = '0;
      nxt_word = word_idx + 1'b1;
    end
    last_data = (byte_idx == LAST_BYTE) && (word_idx == LAST_WORD);
    xfer      = o_tx_valid && i_tx_ready;
  end

  // Dump FSM; every output is registered so the byte on o_tx_data only
  // changes on an accepted transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      snap       <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      trailer    <= 1'b0;
      xor_acc    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            snap       <= i_bus_debug;
            word_idx   <= '0;
            byte_idx   <= '0;
            o_tx_data  <= pick(i_bus_debug, '0, '0);
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= SEND;
`ifdef MEM_DUMP_CHECKSUM_EN
            trailer    <= 1'b0;
            xor_acc    <= '0;
`endif
          end
        end
        SEND: begin
          if (xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            if (trailer) begin
              trailer    <= 1'b0;
              o_tx_valid <= 1'b0;
              o_tx_data  <= '0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              state      <= DONE;
            end else if (last_data) begin
              // Checksum folds in the byte being accepted right now.
              trailer    <= 1'b1;
              xor_acc    <= xor_acc ^ o_tx_data;
              o_tx_data  <= xor_acc ^ o_tx_data;
            end else begin
              xor_acc    <= xor_acc ^ o_tx_data;
              byte_idx   <= nxt_byte;
              word_idx   <= nxt_word;
              o_tx_data  <= pick(snap, nxt_word, nxt_byte);
            end
`else
            if (last_data) begin
              o_tx_valid <= 1'b0;
              o_tx_data  <= '0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              state      <= DONE;
            end else begin
              byte_idx   <= nxt_byte;
              word_idx   <= nxt_word;
              o_tx_data  <= pick(snap, nxt_word, nxt_byte);
            end
`endif
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Testbench for mem_dump_reader: directed steps with randomized data and
// handshake, compared against a word-array byte-stream model.
module tb_mem_dump_reader;

  localparam int IO    = 32;
  localparam int MA    = 5;
  localparam int BS    = 8;
  localparam int WORDS = 2**MA;
  localparam int BPW   = IO/BS;
  localparam int NDATA = WORDS*BPW;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int NTOT  = NDATA + 1;
`else
  localparam int NTOT  = NDATA;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_reset;
  logic                  i_start;
  logic [WORDS*IO-1:0]   i_bus_debug;
  logic                  i_tx_ready;
  logic [BS-1:0]         o_tx_data;
  logic                  o_tx_valid;
  logic                  o_busy;
  logic                  o_done;

  logic [IO-1:0] mem_w  [WORDS];
  logic [IO-1:0] snap_w [WORDS];
  int checks = 0;
  int errors = 0;

  mem_dump_reader #(.IO_BUS_SIZE(IO), .MEM_ADDR_SIZE(MA), .BYTE_SIZE(BS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_bus_debug(i_bus_debug), .i_tx_ready(i_tx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int n = 0; n < WORDS; n++) i_bus_debug[n*IO +: IO] = mem_w[n];
  endtask

  task automatic take_snapshot();
    for (int n = 0; n < WORDS; n++) snap_w[n] = mem_w[n];
  endtask

  // Expected k-th byte of the stream: MSB-first bytes of each word, then
  // (checksum build) the XOR of every data byte.
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] x;
    if (k < NDATA) return 8'(snap_w[k/BPW] >> (8*(BPW-1-(k%BPW))));
    x = '0;
    for (int i = 0; i < NDATA; i++) x ^= 8'(snap_w[i/BPW] >> (8*(BPW-1-(i%BPW))));
    return x;
  endfunction

  // Start a dump and follow it to o_done, with ready asserted pct% of cycles.
  // mutate: overwrite the bus and re-pulse i_start right after the start edge.
  task automatic run_dump(input int pct, input bit mutate);
    int cnt, cyc;
    bit fin, stalled;
    logic [7:0] prev;
    take_snapshot();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cnt = 0; cyc = 0; fin = 0; stalled = 0; prev = '0;
    while (!fin && cyc < 4000) begin
      if (mutate && cyc == 0) begin
        for (int n = 0; n < WORDS; n++) mem_w[n] = '1;
        drive_bus();
        i_start = 1'b1;
      end else if (mutate && cyc == 1) begin
        i_start = 1'b0;
      end
      if (o_done === 1'b1) begin
        fin = 1;
      end else begin
        chk("valid_in_send", o_tx_valid, 1);
        chk("busy_in_send", o_busy, 1);
        if (cnt < NTOT) chk("data", o_tx_data, exp_byte(cnt));
        else chk("overrun_valid", o_tx_valid, 0);
        if (stalled) chk("stall_hold", o_tx_data, prev);
        prev = o_tx_data;
        i_tx_ready = ($urandom_range(99) < pct);
        stalled = !i_tx_ready;
        if (i_tx_ready) cnt++;
        @(negedge i_clk);
        cyc++;
      end
    end
    i_start = 1'b0;
    chk("timeout", fin, 1);
    chk("byte_count", cnt, NTOT);
    chk("done_valid_low", o_tx_valid, 0);
    chk("done_busy_low", o_busy, 0);
    if (pct == 100) chk("cycles", cyc, NTOT);
    i_tx_ready = 1'b0;
    @(negedge i_clk);
    chk("done_one_cycle", o_done, 0);
    chk("idle_valid_low", o_tx_valid, 0);
    repeat (3) @(negedge i_clk);
    chk("no_second_done", o_done, 0);
    chk("no_restart", o_busy, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b1; i_tx_ready = 1'b0;
    for (int n = 0; n < WORDS; n++) mem_w[n] = '0;
    drive_bus();

    // Reset with start held: nothing may begin.
    repeat (3) begin
      @(negedge i_clk);
      chk("rst_valid", o_tx_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
    end
    i_reset = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    chk("post_rst_idle", o_tx_valid, 0);
    chk("post_rst_data", o_tx_data, 0);

    // Full dump, incrementing byte pattern, ready always high.
    for (int n = 0; n < WORDS; n++)
      mem_w[n] = {8'(n), 8'(n+1), 8'(n+2), 8'(n+3)};
    drive_bus();
    run_dump(100, 0);

    // Backpressure with random data.
    for (int n = 0; n < WORDS; n++) mem_w[n] = $urandom;
    mem_w[0] = 32'hDEADBEEF;
    drive_bus();
    run_dump(50, 0);

    // Snapshot isolation and ignored second start.
    for (int n = 0; n < WORDS; n++) mem_w[n] = $urandom;
    drive_bus();
    run_dump(100, 1);

    // Reset mid-dump after 37 transfers, then restart from byte 0.
    for (int n = 0; n < WORDS; n++) mem_w[n] = $urandom;
    drive_bus();
    take_snapshot();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_tx_ready = 1'b1;
    repeat (37) @(negedge i_clk);
    chk("mid_byte37", o_tx_data, exp_byte(37));
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_valid", o_tx_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_data", o_tx_data, 0);
    i_reset = 1'b0; i_tx_ready = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_idle", o_tx_valid, 0);
    run_dump(70, 0);

`ifdef MEM_DUMP_CHECKSUM_EN
    for (int n = 0; n < WORDS; n++) mem_w[n] = 32'h01020304;
    drive_bus();
    run_dump(100, 0);
    for (int n = 0; n < WORDS; n++) mem_w[n] = '0;
    mem_w[0] = 32'h000000FF;
    drive_bus();
    run_dump(60, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
